// File: rtl/mp_mod_reducer.sv
// Limb-serial conditional subtract R = (C >= M) ? C - M : C; done pulses NUM_LIMBS+1 edges after start.
// Optional MPREDUCE_FLAG_EN adds a registered 'reduced' output (1 when the subtraction was applied).
module mp_mod_reducer #(
  parameter int LIMB_W    = 258,
  parameter int NUM_LIMBS = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [514:0] C,
  input  logic [513:0] M,
  output logic [513:0] R,
  output logic         done
`ifdef MPREDUCE_FLAG_EN
  , output logic       reduced
`endif
);

  localparam int W     = LIMB_W * NUM_LIMBS;
  localparam int CNT_W = $clog2(NUM_LIMBS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       regC_q, regC_d;
  logic [W-1:0]       regM_q, regM_d;
  logic [W-1:0]       regD_q, regD_d;
  logic [513:0]       regCkeep_q, regCkeep_d;
  logic               regBorrow_q, regBorrow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [513:0]       R_q, R_d;
  logic               done_q, done_d;
`ifdef MPREDUCE_FLAG_EN
  logic               reduced_q, reduced_d;
`endif

  // Borrow falls out as the top bit of the (LIMB_W+1)-bit difference.
  logic               b_in;
  logic [LIMB_W:0]    sub_w;
  logic [LIMB_W-1:0]  diff;
  logic               b_out;

  assign b_in  = (cnt_q == '0) ? 1'b0 : regBorrow_q;
  assign sub_w = {1'b0, regC_q[LIMB_W-1:0]} - {1'b0, regM_q[LIMB_W-1:0]}
               - {{LIMB_W{1'b0}}, b_in};
  assign diff  = sub_w[LIMB_W-1:0];
  assign b_out = sub_w[LIMB_W];

  // Padding bits of the difference above bit 513 never reach the result.
  logic unused_regD_hi;
  assign unused_regD_hi = ^regD_q[W-1:514];

  always_comb begin
    state_d     = state_q;
    regC_d      = regC_q;
    regM_d      = regM_q;
    regD_d      = regD_q;
    regCkeep_d  = regCkeep_q;
    regBorrow_d = regBorrow_q;
    cnt_d       = cnt_q;
    R_d         = R_q;
    done_d      = 1'b0;
`ifdef MPREDUCE_FLAG_EN
    reduced_d   = reduced_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          regC_d      = W'(C);
          regM_d      = W'(M);
          regCkeep_d  = C[513:0];
          cnt_d       = '0;
          regBorrow_d = 1'b0;
          state_d     = S_SUB;
        end
      end
      S_SUB: begin
        regD_d      = {diff, regD_q[W-1:LIMB_W]};
        regBorrow_d = b_out;
        regC_d      = regC_q >> LIMB_W;
        regM_d      = regM_q >> LIMB_W;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_LIMBS - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        R_d       = regBorrow_q ? regCkeep_q : regD_q[513:0];
        done_d    = 1'b1;
`ifdef MPREDUCE_FLAG_EN
        reduced_d = ~regBorrow_q;
`endif
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      regC_q      <= '0;
      regM_q      <= '0;
      regD_q      <= '0;
      regCkeep_q  <= '0;
      regBorrow_q <= 1'b0;
      cnt_q       <= '0;
      R_q         <= '0;
      done_q      <= 1'b0;
`ifdef MPREDUCE_FLAG_EN
      reduced_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      regC_q      <= regC_d;
      regM_q      <= regM_d;
      regD_q      <= regD_d;
      regCkeep_q  <= regCkeep_d;
      regBorrow_q <= regBorrow_d;
      cnt_q       <= cnt_d;
      R_q         <= R_d;
      done_q      <= done_d;
`ifdef MPREDUCE_FLAG_EN
      reduced_q   <= reduced_d;
`endif
    end
  end

  assign R    = R_q;
  assign done = done_q;
`ifdef MPREDUCE_FLAG_EN
  assign reduced = reduced_q;
`endif

endmodule

// File: tb/tb_mp_mod_reducer.sv
// Scoreboard bench for mp_mod_reducer: directed corner cases plus randomized operands.
module tb_mp_mod_reducer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [514:0] C;
  logic [513:0] M;
  logic [513:0] R;
  logic         done;
`ifdef MPREDUCE_FLAG_EN
  logic         reduced;
`endif

  mp_mod_reducer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .C     (C),
    .M     (M),
    .R     (R),
    .done  (done)
`ifdef MPREDUCE_FLAG_EN
    , .reduced (reduced)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [513:0] r;
    logic         red;
    int unsigned  due;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [513:0] ref_r(input logic [514:0] c, input logic [513:0] m);
    logic [514:0] t;
    t = (c >= {1'b0, m}) ? c - {1'b0, m} : c;
    return t[513:0];
  endfunction

  function automatic logic [514:0] rnd515();
    logic [543:0] t;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    return t[514:0];
  endfunction

  // Monitor: every done pulse must match the oldest expected result and its due cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          n_cmp++;
          if (R !== e.r) begin
            n_bad++;
            $display("FAIL result_R got %h want %h", R, e.r);
          end
          n_cmp++;
          if (cyc != e.due) begin
            n_bad++;
            $display("FAIL done_cycle got %0d want %0d", cyc, e.due);
          end
`ifdef MPREDUCE_FLAG_EN
          n_cmp++;
          if (reduced !== e.red) begin
            n_bad++;
            $display("FAIL reduced_flag got %b want %b", reduced, e.red);
          end
`endif
        end
      end
    end
  end

  task automatic push_exp(input logic [514:0] c, input logic [513:0] m, input int unsigned due);
    exp_t e;
    e.r   = ref_r(c, m);
    e.red = (c >= {1'b0, m});
    e.due = due;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [514:0] c, input logic [513:0] m);
    @(negedge clk);
    start = 1'b1; C = c; M = m;
    @(posedge clk);
    #1;
    push_exp(c, m, cyc + 3);
    @(negedge clk);
    start = 1'b0;
    C = rnd515();
    M = C[513:0];
    wait_drain();
  endtask

  task automatic check_idle_outputs(input string nm, input logic [513:0] want_r);
    n_cmp++;
    if (R !== want_r) begin
      n_bad++;
      $display("FAIL %s_R got %h want %h", nm, R, want_r);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done got %b want 0", nm, done);
    end
`ifdef MPREDUCE_FLAG_EN
    n_cmp++;
    if (reduced !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_reduced got %b want 0", nm, reduced);
    end
`endif
  endtask

  initial begin
    logic [514:0] c;
    logic [513:0] m;
    logic [514:0] r;
    int unsigned  e0;

    rst = 1'b1; start = 1'b0; C = '0; M = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset", '0);
    rst = 1'b0;

    // Directed corner cases
    run_op(515'd10, 514'd7);
    run_op(515'd5, 514'd7);
    run_op(515'd7, 514'd7);
    c = '0; c[258] = 1'b1;
    run_op(c, 514'd1);
    m = '0; m[513] = 1'b1; m[0] = 1'b1;
    c = {m, 1'b0} - 515'd1;
    run_op(c, m);
    c = {m, 1'b0} - 515'd1;
    m = '1;
    run_op(c, m);
    run_op(515'd0, 514'd1);

    // start held high: one op every 4 cycles, extra starts ignored
    @(negedge clk);
    start = 1'b1; C = 515'd10; M = 514'd7;
    @(posedge clk);
    #1;
    e0 = cyc;
    push_exp(515'd10, 514'd7, e0 + 3);
    push_exp(515'd10, 514'd7, e0 + 7);
    push_exp(515'd10, 514'd7, e0 + 11);
    repeat (11) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);

    // Reset during SUB aborts the op with no done pulse afterwards
    @(negedge clk);
    start = 1'b1; C = 515'd5; M = 514'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("midop_reset", '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_op(515'd10, 514'd7);

    // Randomized operands within C < 2M
    for (int i = 0; i < 40; i++) begin
      r = rnd515();
      if (i % 4 == 0) m = 514'($urandom_range(1, 1000));
      else m = r[513:0];
      if (m == '0) m = 514'd1;
      r = rnd515();
      case (i % 5)
        0: c = {1'b0, m};
        1: c = {1'b0, m} - 515'd1;
        2: c = {m, 1'b0} - 515'd1;
        default: c = r % {m, 1'b0};
      endcase
      run_op(c, m);
    end

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
